// File: rtl/pulse_stream_rr_arbiter.sv
// pulse_stream_rr_arbiter: merges sparse per-source pulses into one round-robin ready/valid tile stream
//   clk, rst_n (sync, active-low) | pulse_valid/pulse_vec: per-source strobe + tile
//   out_valid/out_ready/out_vec/out_src: registered output beat tagged with source
//   drop_cnt: per-source saturating lost-pulse count | busy: any slot or beat pending
module pulse_stream_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int TILE_SIZE = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DROP_CNT_W = 8,
  localparam int SRC_W = $clog2(NUM_SRC)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_SRC-1:0] pulse_valid,
  input  logic signed [NUM_SRC-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] pulse_vec,
  output logic out_valid,
  input  logic out_ready,
  output logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0] out_vec,
  output logic [SRC_W-1:0] out_src,
  output logic [NUM_SRC-1:0][DROP_CNT_W-1:0] drop_cnt,
  output logic busy
);
  logic [NUM_SRC-1:0] slot_valid;
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] slot_vec [NUM_SRC];
  logic [SRC_W-1:0] rr_ptr, gnt, idx;
  logic gnt_valid, fire, out_free;
  assign fire = out_valid & out_ready;
  assign out_free = !out_valid | fire;
  assign busy = |slot_valid | out_valid;
  // scan from the farthest slot back to rr_ptr so the nearest valid slot wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
      if (out_free && slot_valid[idx]) begin
        gnt_valid = 1'b1;
        gnt = idx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid <= '0;
      out_valid <= 1'b0;
      out_vec <= '0;
      out_src <= '0;
      drop_cnt <= '0;
      rr_ptr <= '0;
    end else begin
      if (gnt_valid) begin
        out_vec <= slot_vec[gnt];
        out_src <= gnt;
        out_valid <= 1'b1;
        slot_valid[gnt] <= 1'b0;
        rr_ptr <= (gnt == SRC_W'(NUM_SRC - 1)) ? '0 : gnt + 1'b1;
      end else if (fire) begin
        out_valid <= 1'b0;
      end
      // a slot emptied by this cycle's grant can refill at once; written after the clear so it wins
      for (int i = 0; i < NUM_SRC; i++) begin
        if (pulse_valid[i]) begin
          if (!slot_valid[i] || (gnt_valid && gnt == SRC_W'(i))) begin
            slot_valid[i] <= 1'b1;
            slot_vec[i] <= pulse_vec[i];
          end else if (drop_cnt[i] != '1) begin
            drop_cnt[i] <= drop_cnt[i] + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pulse_stream_rr_arbiter.sv
// tb_pulse_stream_rr_arbiter: directed scoreboard bench for pulse_stream_rr_arbiter
module tb_pulse_stream_rr_arbiter;
  localparam int NS = 4;
  localparam int TS = 4;
  localparam int DW = 16;
  localparam int DCW = 2;
  localparam int SW = 2;
  typedef logic signed [TS-1:0][DW-1:0] vec_t;
  typedef struct { int src; vec_t vec; } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [NS-1:0] pulse_valid;
  logic signed [NS-1:0][TS-1:0][DW-1:0] pulse_vec;
  logic out_valid, out_ready, busy;
  vec_t out_vec;
  logic [SW-1:0] out_src;
  logic [NS-1:0][DCW-1:0] drop_cnt;
  exp_t sb[$];
  int src_log[$];
  int n_chk = 0, n_fail = 0, n_beats = 0, k, nb;
  vec_t v1;
  pulse_stream_rr_arbiter #(.NUM_SRC(NS), .TILE_SIZE(TS), .DATA_WIDTH(DW), .DROP_CNT_W(DCW)) dut (
    .clk(clk), .rst_n(rst_n), .pulse_valid(pulse_valid), .pulse_vec(pulse_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_src(out_src),
    .drop_cnt(drop_cnt), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic vec_t mk(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = DW'(a);
    v[1] = DW'(b);
    v[2] = DW'(c);
    v[3] = DW'(d);
    return v;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic neg();
    @(negedge clk);
  endtask
  task automatic drive(input int s, input vec_t v, input bit cap);
    pulse_valid[s] = 1'b1;
    pulse_vec[s] = v;
    if (cap) sb.push_back('{s, v});
  endtask
  // every accepted beat must match the oldest outstanding pulse of its source
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      k = -1;
      for (int i = 0; i < sb.size(); i++) if (k < 0 && sb[i].src == int'(out_src)) k = i;
      check("beat_expected", 64'(k >= 0), 64'd1);
      if (k >= 0) begin
        check("beat_vec", out_vec, sb[k].vec);
        sb.delete(k);
      end
      src_log.push_back(int'(out_src));
      n_beats++;
    end
  end
  initial begin
    pulse_valid = '0;
    pulse_vec = '0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    neg();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_out_src", out_src, 0);
    check("rst_out_vec", out_vec, 0);
    rst_n = 1'b1;
    // T1 single pulse latency
    step();
    drive(2, mk(1, 2, 3, 4), 1);
    step();
    pulse_valid = '0;
    neg();
    check("t1_valid_t1", out_valid, 0);
    step();
    neg();
    check("t1_valid_t2", out_valid, 1);
    check("t1_src", out_src, 2);
    check("t1_vec", out_vec, mk(1, 2, 3, 4));
    step();
    neg();
    check("t1_valid_t3", out_valid, 0);
    check("t1_busy_t3", busy, 0);
    check("t1_beats", n_beats, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    // T2 all sources at once from rr_ptr=0
    for (int s = 0; s < NS; s++) drive(s, mk(10 + s, 20 + s, -s, s * 100), 1);
    step();
    pulse_valid = '0;
    step();
    for (int i = 0; i < NS; i++) begin
      neg();
      check("t2_valid", out_valid, 1);
      check("t2_src", out_src, i);
      step();
    end
    neg();
    check("t2_idle", out_valid, 0);
    drive(3, mk(33, 0, 0, 0), 1);
    drive(0, mk(30, 0, 0, 0), 1);
    step();
    pulse_valid = '0;
    step();
    neg();
    check("t2_rr_first", out_src, 0);
    step();
    neg();
    check("t2_rr_second", out_src, 3);
    step();
    // T3 backpressure hold then drain
    out_ready = 1'b0;
    v1 = mk(-7, 8, -9, 10);
    drive(1, v1, 1);
    drive(2, mk(2, 2, 2, 2), 1);
    drive(3, mk(3, 3, 3, 3), 1);
    step();
    pulse_valid = '0;
    step();
    for (int i = 0; i < 10; i++) begin
      neg();
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_src", out_src, 1);
      check("t3_hold_vec", out_vec, v1);
      if (i == 2) drive(0, mk(5, 5, 5, 5), 1);
      else pulse_valid = '0;
      step();
    end
    pulse_valid = '0;
    src_log.delete();
    out_ready = 1'b1;
    repeat (5) step();
    check("t3_drain_n", src_log.size(), 4);
    check("t3_drain_0", src_log[0], 1);
    check("t3_drain_1", src_log[1], 2);
    check("t3_drain_2", src_log[2], 3);
    check("t3_drain_3", src_log[3], 0);
    // T4 drop counting and saturation
    out_ready = 1'b0;
    drive(0, mk(7, 7, 7, 7), 1);
    step();
    pulse_valid = '0;
    step();
    neg();
    check("t4_held", out_valid, 1);
    for (int i = 0; i < 6; i++) begin
      drive(3, mk(40 + i, 41, 42, 43), i == 0);
      step();
      neg();
      check("t4_drop3", drop_cnt[3], (i > 3) ? 3 : i);
      check("t4_drop_other", {drop_cnt[2], drop_cnt[1], drop_cnt[0]}, 0);
    end
    pulse_valid = '0;
    out_ready = 1'b1;
    repeat (4) step();
    check("t4_drained", busy, 0);
    // T5 same-cycle refill of a granted slot
    nb = n_beats;
    drive(0, mk(100, 101, 102, 103), 1);
    step();
    drive(0, mk(200, 201, 202, 203), 1);
    step();
    pulse_valid = '0;
    neg();
    check("t5_drop0", drop_cnt[0], 0);
    check("t5_first_vec", out_vec, mk(100, 101, 102, 103));
    step();
    neg();
    check("t5_second_valid", out_valid, 1);
    check("t5_second_vec", out_vec, mk(200, 201, 202, 203));
    step();
    check("t5_beats", n_beats - nb, 2);
    // T6 reset in the middle of traffic
    out_ready = 1'b0;
    for (int s = 0; s < NS; s++) drive(s, mk(60 + s, 0, 0, 0), 1);
    step();
    pulse_valid = '0;
    step();
    neg();
    check("t6_pre_valid", out_valid, 1);
    check("t6_pre_busy", busy, 1);
    rst_n = 1'b0;
    sb.delete();
    step();
    rst_n = 1'b1;
    neg();
    check("t6_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_drop_cnt", drop_cnt, 0);
    out_ready = 1'b1;
    drive(1, mk(-1, -2, -3, -4), 1);
    step();
    pulse_valid = '0;
    neg();
    check("t6_valid_t1", out_valid, 0);
    step();
    neg();
    check("t6_valid_t2", out_valid, 1);
    check("t6_src", out_src, 1);
    check("t6_vec", out_vec, mk(-1, -2, -3, -4));
    step();
    neg();
    check("t6_busy_t3", busy, 0);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
